// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master: state encoding and bus widths.
package wb_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    WBM_IDLE = 2'd0,
    WBM_BUS  = 2'd1,
    WBM_RESP = 2'd2
  } wbm_state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one bus cycle and
// one valid/ready response. A stuck slave is cut off after TIMEOUT_CYCLES strobes.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int          ADR_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_wen,
  input  logic [ADR_W-1:0]    i_cmd_adr,
  input  logic [WB_DAT_W-1:0] i_cmd_dat,
  input  logic [WB_SEL_W-1:0] i_cmd_sel,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [WB_DAT_W-1:0] o_rsp_dat,
  output logic                o_rsp_err,
  output logic [ADR_W-1:0]    o_wb_adr,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic [WB_SEL_W-1:0] o_wb_sel,
  output logic                o_wb_wen,
  output logic                o_wb_stb,
  output logic                o_wb_cyc,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  input  logic                i_wb_ack
);

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  wbm_state_e          state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADR_W-1:0]    wb_adr_q, wb_adr_d;
  logic [WB_DAT_W-1:0] wb_dat_q, wb_dat_d;
  logic [WB_SEL_W-1:0] wb_sel_q, wb_sel_d;
  logic                wb_wen_q, wb_wen_d;
  logic                wb_stb_q, wb_stb_d;
  logic                wb_cyc_q, wb_cyc_d;

  logic cmd_fire;
  logic ack_hit;
  logic to_hit;
  logic rsp_fire;

  // Ack is only honoured inside BUS, and it takes priority over a coincident timeout.
  assign cmd_fire = (state_q == WBM_IDLE) && i_cmd_valid && cmd_ready_q;
  assign ack_hit  = (state_q == WBM_BUS) && i_wb_ack;
  assign to_hit   = (state_q == WBM_BUS) && !i_wb_ack && TO_EN && (cnt_q == TO_LAST);
  assign rsp_fire = (state_q == WBM_RESP) && i_rsp_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= WBM_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_sel_q    <= '0;
      wb_wen_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_cyc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      wb_sel_q    <= wb_sel_d;
      wb_wen_q    <= wb_wen_d;
      wb_stb_q    <= wb_stb_d;
      wb_cyc_q    <= wb_cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WBM_IDLE: if (cmd_fire) state_d = WBM_BUS;
      WBM_BUS:  if (ack_hit || to_hit) state_d = WBM_RESP;
      WBM_RESP: if (rsp_fire) state_d = WBM_IDLE;
      default:  state_d = WBM_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_d    = wb_dat_q;
    wb_sel_d    = wb_sel_q;
    wb_wen_d    = wb_wen_q;
    wb_stb_d    = wb_stb_q;
    wb_cyc_d    = wb_cyc_q;
    unique case (state_q)
      WBM_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_fire) begin
          wb_adr_d    = i_cmd_adr;
          wb_dat_d    = i_cmd_dat;
          wb_sel_d    = i_cmd_sel;
          wb_wen_d    = i_cmd_wen;
          wb_stb_d    = 1'b1;
          wb_cyc_d    = 1'b1;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
        end
      end
      WBM_BUS: begin
        if (ack_hit || to_hit) begin
          wb_stb_d    = 1'b0;
          wb_cyc_d    = 1'b0;
          wb_wen_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = to_hit;
          rsp_dat_d   = (ack_hit && !wb_wen_q) ? i_wb_dat : '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WBM_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
        wb_stb_d    = 1'b0;
        wb_cyc_d    = 1'b0;
      end
    endcase
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_dat   = rsp_dat_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wb_adr    = wb_adr_q;
  assign o_wb_dat    = wb_dat_q;
  assign o_wb_sel    = wb_sel_q;
  assign o_wb_wen    = wb_wen_q;
  assign o_wb_stb    = wb_stb_q;
  assign o_wb_cyc    = wb_cyc_q;

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone initiator that turns single-word command requests into classic Wishbone read/write cycles toward the peripheral register slaves (timer, etc.). It is driven by a valid/ready command port, for example from a debug/UART bridge or a test sequencer. It returns read data or an error on a valid/ready response port. A programmable timeout protects against absent or hung slaves.

Parameters:
ADR_W, 4, width of o_wb_adr and i_cmd_adr
TIMEOUT_CYCLES, 255, maximum cycles o_wb_stb stays high without i_wb_ack; 0 disables the timeout (wait forever)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_cmd_valid  input  1  command request
o_cmd_ready  output  1  command accept
i_cmd_wen  input  1  1=write, 0=read
i_cmd_adr  input  ADR_W  register address
i_cmd_dat  input  32  write data
i_cmd_sel  input  4  byte enables
o_rsp_valid  output  1  response available
i_rsp_ready  input  1  response consumed
o_rsp_dat  output  32  read data (0 for writes/errors)
o_rsp_err  output  1  1 = timeout
o_wb_adr  output  ADR_W  bus address
o_wb_dat  output  32  bus write data
o_wb_sel  output  4  bus byte select
o_wb_wen  output  1  bus write enable
o_wb_stb  output  1  strobe
o_wb_cyc  output  1  cycle
i_wb_dat  input  32  bus read data
i_wb_ack  input  1  slave acknowledge (single-cycle pulse)

Behaviour:
- All outputs are registered. Reset (i_rst=1 at an edge), including mid-transaction, forces the following at that edge: state IDLE; o_wb_stb=o_wb_cyc=o_wb_wen=0; o_wb_adr/dat/sel=0; o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=0; o_cmd_ready=0; counter=0.
- States:
  - IDLE: o_cmd_ready=1 (registered; rises on the first edge after reset release). On an edge with i_cmd_valid && o_cmd_ready:
    - capture adr/dat/sel/wen into the o_wb_* registers;
    - set o_wb_stb=o_wb_cyc=1 and o_cmd_ready=0;
    - clear the counter and go to BUS.
  - BUS: stb, cyc and all o_wb_* fields are held stable.
    - Edge with i_wb_ack=1:
      - drop stb/cyc/wen;
      - o_rsp_dat = i_wb_dat for a read, 0 for a write;
      - o_rsp_err=0, o_rsp_valid=1; go to RESP.
    - Edge with no ack and TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1:
      - drop stb/cyc/wen;
      - o_rsp_dat=0, o_rsp_err=1, o_rsp_valid=1; go to RESP.
    - Otherwise the counter increments.
    - Result: stb is high for at most TIMEOUT_CYCLES cycles.
  - RESP: o_rsp_valid and o_rsp_dat/o_rsp_err are held until an edge with i_rsp_ready=1. At that edge: o_rsp_valid=0, o_cmd_ready=1, go to IDLE.
- Latency:
  - stb rises 1 edge after command acceptance.
  - stb falls on the edge that samples ack. This is the guaranteed deassert required by slaves that return to their idle state 1 cycle after their ack pulse.
  - A command can be accepted at the earliest 1 cycle after response acceptance, so back-to-back bus cycles always have at least 2 idle cycles of stb.
- Simultaneous ack and timeout on the same edge: ack wins, normal response.
- i_wb_ack while not in BUS (late ack after timeout, spurious): ignored, no state change.
- i_rsp_ready while not in RESP: ignored.
- The counter is 32 bits, saturating, and is not used when TIMEOUT_CYCLES=0.

Decomposition:
- Shared package wb_pkg:
  - state encoding constants (WBM_IDLE=0, WBM_BUS=1, WBM_RESP=2);
  - WB_DAT_W=32, WB_SEL_W=4.
- No sub-module is needed. The timeout counter is inline in the state machine.

Test Plan:
- Write to timer slave: cmd wen=1, adr=4, dat=32'h0000000A, sel=4'hF → stb high until ack; response err=0, dat=0. A following read of adr=4 returns 32'h0000000A.
- Partial write: adr=4, dat=32'h12345678, sel=4'b0001 on top of 32'h0000000A → readback 32'h00000078.
- Timeout: no slave attached (ack tied 0), TIMEOUT_CYCLES=8, read adr=0 → stb high exactly 8 cycles, then response err=1, dat=0. An ack injected 3 cycles later is ignored.
- Response back-pressure: hold i_rsp_ready=0 for 5 cycles after a read of adr=0 → o_rsp_valid stays 1, dat stable, o_cmd_ready stays 0, no new stb. Releasing ready → cmd_ready=1 on the next edge.
- Ack coincident with the timeout edge (TIMEOUT_CYCLES=4, ack on the 4th cycle) → err=0 with the ack data.
- Reset asserted while in BUS with stb=1 → stb, cyc, rsp_valid and cmd_ready are all 0 after that edge. cmd_ready returns to 1 one edge after reset deasserts, and the next command completes normally.
